ts_chan_rr_sched: RTL and testbench
===================================

Name: ts_chan_rr_sched

Overview:
- Packet-level round-robin scheduler for the four 33-bit receive channels produced by the per-SFP 8-to-32 receive buffers.
- Decides which channel owns the shared 33-bit output path.
- Issues that channel's rd_ack strobes for exactly one TS packet, then registers the returned words onto a single output stream.
- Checks packet-start alignment and counts violations.

Parameters:
- PKT_WORDS, 47, words per TS packet (188 bytes / 4); legal range 2..255.
- GAP_CYCLES, 0, extra idle cycles inserted after each packet before the next arbitration; range 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ch_en  in  4  per-channel enable; bit n gates channel n+1
- data_in1..data_in4  in  33  channel words; bit 32 = packet-start marker, [31:0] = payload
- data_in1_valid..data_in4_valid  in  1  high = source holds at least one complete packet
- rd_ack1..rd_ack4  out  1  one-word read strobe to the source
- data_out  out  33  scheduled word
- data_out_valid  out  1  data_out qualifier
- cur_chan  out  2  index of the channel granted last (0..3)
- sync_err  out  1  one-cycle pulse on a misaligned packet
- err_cnt  out  8  saturating count of sync_err pulses

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE; RR pointer = 3, so channel 1 wins first.
  - Word counter, gap counter and read-valid pipeline are cleared.
- Source contract: a word appears on data_inN exactly 1 cycle after its rd_ackN.
- States: IDLE, GRANT, DRAIN, GAP.
- IDLE:
  - Request vector req[n] = data_in(n+1)_valid & ch_en[n].
  - Winner = first set bit searching upward from RR pointer+1, wrapping 3 to 0.
  - If any request is set: latch winner into cur_chan, set RR pointer = winner, go to GRANT.
  - If no request is set: remain in IDLE.
- GRANT:
  - rd_ack of the granted channel is high for exactly PKT_WORDS consecutive cycles; all other rd_acks are 0.
  - Then go to DRAIN.
- DRAIN: one cycle to capture the last returned word, then go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency and timing:
  - rd_ack to data_out_valid is 2 cycles: 1 cycle source read, 1 cycle output register.
  - data_out_valid is high for exactly PKT_WORDS consecutive cycles per packet, with no bubbles.
  - With GAP_CYCLES=0: IDLE decides at cycle t, rd_ack is high t+1..t+PKT_WORDS, DRAIN at t+PKT_WORDS+1, next decision at t+PKT_WORDS+2.
- Data path: data_out is the captured word of the granted channel, unmodified (bit 32 passes through).
- Alignment check:
  - First word of a packet with bit32=0: sync_err pulses in the same cycle data_out_valid shows that word; err_cnt increments, saturating at 255.
  - A non-first word with bit32=1 is also a sync error.
  - The packet is still forwarded in full; sync_err never aborts a grant.
- Mid-packet changes of the granted channel's valid or ch_en bit are ignored; a grant is committed once issued.
- Channels with valid low or ch_en bit low are skipped.
- All channels idle: remain in IDLE; the RR pointer is unchanged.
- Reset asserted mid-packet: the packet is truncated immediately and no further rd_ack is issued. The source is responsible for its own resync.
- err_cnt is cleared only by reset.

Decomposition:
- Shared package ts_split_pkg holds:
  - Word width constants: W_DATA=32, W_WORD=33, SOP_BIT=32.
  - TS_PKT_WORDS=47.
  - State encoding constants.
- Sub-module rr_arb4: combinational 4-way rotating-priority picker (req[3:0], ptr[1:0] -> gnt_idx[1:0], gnt_any).
- The FSM, counters and datapath stay in ts_chan_rr_sched.

Test Plan:
1. Only channel 2 valid, aligned packet of 47 words with bit32=1 on word 0 -> rd_ack2 high 47 cycles starting 1 cycle after decision; data_out_valid high 47 cycles, 2 cycles after rd_ack2; cur_chan=1; sync_err never pulses.
2. All four valid continuously, GAP_CYCLES=0 -> grant order 1,2,3,4,1; consecutive rd_ack bursts separated by exactly 2 idle cycles; no rd_ack overlap.
3. Channels 1 and 3 valid, ch_en=4'b1011 -> only channel 1 is served; with ch_en=4'b1111, alternation 1,3,1,3.
4. Channel 4 packet with word0 bit32=0, then a good packet -> sync_err is a single pulse aligned to first output word; err_cnt=1; both packets forwarded with 47 valid words each.
5. 260 misaligned packets -> err_cnt saturates at 255.
6. reset driven low at word 20 of a grant -> all rd_acks and data_out_valid drop asynchronously; after release, the first grant goes to channel 1 if requesting.

Source files
------------

// File: rtl/ts_split_pkg.sv
// Shared constants for the TS receive split/schedule path.
// Word layout, packet size and scheduler state encoding.
package ts_split_pkg;

    localparam int W_DATA       = 32;
    localparam int W_WORD       = 33;
    localparam int SOP_BIT      = W_DATA;
    localparam int TS_PKT_WORDS = 47;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

endpackage

// File: rtl/ts_chan_rr_sched_rr_arb4.sv
// Four-way rotating-priority picker: first request above ptr wins.
// Purely combinational; the caller owns the pointer register.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    logic [1:0] idx;

    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/ts_chan_rr_sched.sv
// Packet-level round-robin scheduler for four 33-bit receive channels.
// Grants one full TS packet per decision and checks start-of-packet alignment.
module ts_chan_rr_sched
    import ts_split_pkg::*;
#(
    parameter int PKT_WORDS  = TS_PKT_WORDS,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ch_en,
    input  logic [W_WORD-1:0] data_in1,
    input  logic [W_WORD-1:0] data_in2,
    input  logic [W_WORD-1:0] data_in3,
    input  logic [W_WORD-1:0] data_in4,
    input  logic              data_in1_valid,
    input  logic              data_in2_valid,
    input  logic              data_in3_valid,
    input  logic              data_in4_valid,
    output logic              rd_ack1,
    output logic              rd_ack2,
    output logic              rd_ack3,
    output logic              rd_ack4,
    output logic [W_WORD-1:0] data_out,
    output logic              data_out_valid,
    output logic [1:0]        cur_chan,
    output logic              sync_err,
    output logic [7:0]        err_cnt
);

    localparam logic [7:0] PKT_LAST = 8'(PKT_WORDS - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        chan_q, chan_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [3:0]        gcnt_q, gcnt_d;
    logic              rv_q, rfirst_q;
    logic [W_WORD-1:0] dout_q;
    logic              dov_q, serr_q;
    logic [7:0]        ecnt_q;

    logic [3:0]        req, ack;
    logic [1:0]        win;
    logic              win_any;
    logic [W_WORD-1:0] word;
    logic              bad;

    assign req = ch_en & {data_in4_valid, data_in3_valid,
                          data_in2_valid, data_in1_valid};

    rr_arb4 u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (win),
        .gnt_any (win_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        chan_d  = chan_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    state_d = S_GRANT;
                    chan_d  = win;
                    ptr_d   = win;
                    wcnt_d  = 8'd0;
                end
            end
            S_GRANT: begin
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == PKT_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                gcnt_d  = 4'd0;
                state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                gcnt_d = gcnt_q + 4'd1;
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded from registered state so reset kills the strobes at once.
    assign ack = (state_q == S_GRANT) ? (4'b0001 << chan_q) : 4'b0000;

    always_comb begin
        word = data_in1;
        unique case (chan_q)
            2'd0: word = data_in1;
            2'd1: word = data_in2;
            2'd2: word = data_in3;
            2'd3: word = data_in4;
            default: word = data_in1;
        endcase
    end

    assign bad = rfirst_q ? ~word[SOP_BIT] : word[SOP_BIT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= 2'd3;
            chan_q   <= 2'd0;
            wcnt_q   <= 8'd0;
            gcnt_q   <= 4'd0;
            rv_q     <= 1'b0;
            rfirst_q <= 1'b0;
            dout_q   <= '0;
            dov_q    <= 1'b0;
            serr_q   <= 1'b0;
            ecnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            chan_q   <= chan_d;
            wcnt_q   <= wcnt_d;
            gcnt_q   <= gcnt_d;
            rv_q     <= |ack;
            rfirst_q <= (state_q == S_GRANT) && (wcnt_q == 8'd0);
            dov_q    <= rv_q;
            serr_q   <= rv_q & bad;
            if (rv_q) begin
                dout_q <= word;
            end
            if (rv_q && bad && ecnt_q != 8'hFF) begin
                ecnt_q <= ecnt_q + 8'd1;
            end
        end
    end

    assign rd_ack1        = ack[0];
    assign rd_ack2        = ack[1];
    assign rd_ack3        = ack[2];
    assign rd_ack4        = ack[3];
    assign data_out       = dout_q;
    assign data_out_valid = dov_q;
    assign cur_chan       = chan_q;
    assign sync_err       = serr_q;
    assign err_cnt        = ecnt_q;

endmodule

// File: tb/tb_ts_chan_rr_sched.sv
// Scoreboard bench for ts_chan_rr_sched: modelled sources push expected words,
// the output monitor pops and compares them and tracks grant order and timing.
module tb_ts_chan_rr_sched;

    localparam int P = 47;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ch_en = 4'hF;
    logic [32:0] din [4];
    logic        rd_ack1, rd_ack2, rd_ack3, rd_ack4;
    logic [32:0] data_out;
    logic        data_out_valid;
    logic [1:0]  cur_chan;
    logic        sync_err;
    logic [7:0]  err_cnt;

    int          pkts [4];
    int          src_idx [4];
    int          bad_left [4];
    int          pktno [4];
    bit          bad_cur [4];
    bit [3:0]    ack_seen;
    logic [33:0] sb [$];
    int          grant_log [$];
    int          gap_log [$];
    int          ack_starts [$];
    int          cyc = 0;
    int          blen = 0, orun = 0, bch = 0, last_end = -1;
    int          err_model = 0, serr_pulses = 0;
    int          n_chk = 0, n_pass = 0;
    logic [3:0]  a;
    logic [33:0] e;

    always #5 clk = ~clk;

    ts_chan_rr_sched dut (
        .clk            (clk),
        .reset          (reset),
        .ch_en          (ch_en),
        .data_in1       (din[0]),
        .data_in2       (din[1]),
        .data_in3       (din[2]),
        .data_in4       (din[3]),
        .data_in1_valid (pkts[0] > 0),
        .data_in2_valid (pkts[1] > 0),
        .data_in3_valid (pkts[2] > 0),
        .data_in4_valid (pkts[3] > 0),
        .rd_ack1        (rd_ack1),
        .rd_ack2        (rd_ack2),
        .rd_ack3        (rd_ack3),
        .rd_ack4        (rd_ack4),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .cur_chan       (cur_chan),
        .sync_err       (sync_err),
        .err_cnt        (err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int first_idx(input logic [3:0] v);
        if (v[0]) return 0;
        if (v[1]) return 1;
        if (v[2]) return 2;
        return 3;
    endfunction

    // Sources: a word appears one cycle after its rd_ack.
    always @(posedge clk) begin
        logic sop;
        logic [32:0] w;
        cyc++;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (ack_seen[ch]) begin
                if (src_idx[ch] == 0) begin
                    bad_cur[ch] = bad_left[ch] > 0;
                    if (bad_cur[ch]) bad_left[ch]--;
                end
                if (src_idx[ch] == 0)
                    sop = !(bad_cur[ch] && !pktno[ch][0]);
                else
                    sop = bad_cur[ch] && pktno[ch][0] && src_idx[ch] == 5;
                w = {sop, 2'(ch), 6'($urandom), 8'(pktno[ch]), 16'(src_idx[ch])};
                din[ch] = w;
                sb.push_back({(src_idx[ch] == 0) ? !sop : sop, w});
                src_idx[ch]++;
                if (src_idx[ch] == P) begin
                    src_idx[ch] = 0;
                    pktno[ch]++;
                    pkts[ch]--;
                end
            end
        end
    end

    always @(negedge clk) begin
        a = {rd_ack4, rd_ack3, rd_ack2, rd_ack1};
        ack_seen = reset ? a : 4'b0;
        if (!reset) begin
            blen = 0;
            orun = 0;
            last_end = -1;
            ack_starts.delete();
        end else begin
            if (a != 4'b0) begin
                check("ack_onehot", 64'($onehot(a)), 1);
                if (blen == 0) begin
                    bch = first_idx(a);
                    grant_log.push_back(bch);
                    check("cur_chan", cur_chan, bch);
                    if (last_end >= 0) gap_log.push_back(cyc - last_end - 1);
                    ack_starts.push_back(cyc);
                end else begin
                    check("ack_chan", a, 4'b0001 << bch);
                end
                blen++;
            end else if (blen > 0) begin
                check("burst_len", blen, P);
                last_end = cyc - 1;
                blen = 0;
            end
            if (data_out_valid) begin
                if (orun == 0) begin
                    check("ack_start_known", 64'(ack_starts.size() > 0), 1);
                    if (ack_starts.size() > 0)
                        check("latency", cyc - ack_starts.pop_front(), 2);
                end
                orun++;
                check("sb_avail", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("data_out", data_out, e[32:0]);
                    check("sync_err", sync_err, e[33]);
                    if (e[33] && err_model < 255) err_model++;
                    check("err_cnt", err_cnt, err_model);
                end
            end else if (orun > 0) begin
                check("out_run", orun, P);
                orun = 0;
            end
            if (sync_err) serr_pulses++;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {data_out, data_out_valid, cur_chan, sync_err,
                              err_cnt, rd_ack4, rd_ack3, rd_ack2, rd_ack1}, 0);
        repeat (2) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            pkts[ch] = 0;
            src_idx[ch] = 0;
            bad_left[ch] = 0;
            pktno[ch] = 0;
            bad_cur[ch] = 0;
        end
        sb.delete();
        grant_log.delete();
        gap_log.delete();
        err_model = 0;
        serr_pulses = 0;
        ch_en = 4'hF;
        reset = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = sb.size() == 0 && !data_out_valid &&
                   {rd_ack4, rd_ack3, rd_ack2, rd_ack1} == 4'b0;
            for (int ch = 0; ch < 4; ch++)
                if (ch_en[ch] && pkts[ch] > 0) done = 0;
        end
        check("timeout", 64'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_grants(input string tag, input int exp[$]);
        check({tag, "_n"}, grant_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < grant_log.size()) ? grant_log[i] : -1, exp[i]);
    endtask

    initial begin
        int n;
        for (int ch = 0; ch < 4; ch++) din[ch] = '0;
        ack_seen = '0;

        do_reset();
        pkts[1] = 1;
        wait_done(500);
        check_grants("t1_grant", '{1});
        check("t1_serr", serr_pulses, 0);

        do_reset();
        pkts[0] = 2; pkts[1] = 1; pkts[2] = 1; pkts[3] = 1;
        wait_done(1000);
        check_grants("t2_grant", '{0, 1, 2, 3, 0});
        check("t2_gap_n", gap_log.size(), 4);
        foreach (gap_log[i]) check("t2_gap", gap_log[i], 2);

        do_reset();
        ch_en = 4'b1011;
        pkts[0] = 2; pkts[2] = 2;
        wait_done(1000);
        check_grants("t3a_grant", '{0, 0});
        grant_log.delete();
        ch_en = 4'b1111;
        pkts[0] = 2;
        wait_done(1000);
        check_grants("t3b_grant", '{2, 0, 2, 0});

        do_reset();
        pkts[3] = 2; bad_left[3] = 1;
        wait_done(500);
        check_grants("t4_grant", '{3, 3});
        check("t4_pulses", serr_pulses, 1);
        check("t4_err_cnt", err_cnt, 1);

        do_reset();
        pkts[0] = 260; bad_left[0] = 260;
        wait_done(20000);
        check("t5_pulses", serr_pulses, 260);
        check("t5_err_cnt", err_cnt, 255);

        do_reset();
        pkts[2] = 3;
        n = 0;
        while (blen != 20 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_w20", blen, 20);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("t6_async_drop", {rd_ack4, rd_ack3, rd_ack2, rd_ack1,
                                   data_out_valid}, 0);
        do_reset();
        pkts[0] = 1; pkts[2] = 1;
        wait_done(500);
        check_grants("t6_grant", '{0, 2});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
